// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the fetch-to-dispatch instruction queue.
package inst_queue_pkg;

   localparam int IQ_DEPTH = 4;

   typedef logic [31:0] inst_t;
   typedef logic [63:0] dword_t;

   localparam inst_t INST_NOP = 32'h0000_0013;

   typedef struct packed {
      dword_t pc;
      inst_t  inst;
   } iq_entry_t;

   // Instruction fetch addresses must be 4-byte aligned.
   function automatic logic pc_misaligned(input dword_t pc);
      return (pc[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/inst_queue_sync_fifo.sv
// Generic synchronous FIFO with a synchronous clear; storage resets to RST_VAL
// so the read port never presents X.
module inst_queue_sync_fifo
   import inst_queue_pkg::*;
#(
   parameter int                WIDTH   = $bits(iq_entry_t),
   parameter int                DEPTH   = IQ_DEPTH,
   parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}},
   localparam int               PTR_W   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic [PTR_W:0]   o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W:0]   r_count;
   logic             w_wr;
   logic             w_rd;

   assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
   assign o_empty   = (r_count == {(PTR_W+1){1'b0}});
   assign w_wr      = i_wr_en & ~o_full & ~i_clear;
   assign w_rd      = i_rd_en & ~o_empty & ~i_clear;
   assign o_rd_data = r_mem[r_head];
   assign o_count   = r_count;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= {PTR_W{1'b0}};
         r_tail  <= {PTR_W{1'b0}};
         r_count <= {(PTR_W+1){1'b0}};
      end else if (i_clear) begin
         r_head  <= {PTR_W{1'b0}};
         r_tail  <= {PTR_W{1'b0}};
         r_count <= {(PTR_W+1){1'b0}};
      end else begin
         if (w_wr) r_tail <= r_tail + PTR_W'(1);
         if (w_rd) r_head <= r_head + PTR_W'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= RST_VAL;
      end else if (w_wr) begin
         r_mem[r_tail] <= i_wr_data;
      end
   end

endmodule

// File: rtl/inst_queue.sv
// Instruction queue between fetch and dispatch: FIFO of (pc, inst) with
// redirect flush, misalign decode and a NOP head value out of reset.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH = IQ_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   input  logic           in_valid,
   output logic           in_ready,
   input  dword_t         in_pc,
   input  inst_t          in_inst,
   output logic           out_valid,
   input  logic           out_ready,
   output dword_t         out_pc,
   output inst_t          out_inst,
   output logic           out_misalign,
   output logic [PTR_W:0] count
);

   logic      w_push;
   logic      w_pop;
   logic      w_full;
   logic      w_empty;
   iq_entry_t w_wr_entry;
   iq_entry_t w_head;

   assign w_wr_entry = '{pc: in_pc, inst: in_inst};
   assign w_push     = in_valid & in_ready & ~flush;
   assign w_pop      = out_valid & out_ready;

   inst_queue_sync_fifo #(
      .WIDTH   ($bits(iq_entry_t)),
      .DEPTH   (DEPTH),
      .RST_VAL ({64'h0, INST_NOP})
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (flush),
      .i_wr_en   (w_push),
      .i_wr_data (w_wr_entry),
      .i_rd_en   (w_pop),
      .o_rd_data (w_head),
      .o_count   (count),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   // in_ready depends only on occupancy, never on out_ready.
   assign in_ready     = ~w_full;
   assign out_valid    = ~w_empty & ~flush;
   assign out_pc       = w_head.pc;
   assign out_inst     = w_head.inst;
   assign out_misalign = pc_misaligned(w_head.pc);

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a reference queue tracks accepted entries.
module tb_inst_queue;
   import inst_queue_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   dword_t     in_pc;
   inst_t      in_inst;
   logic       out_valid;
   logic       out_ready;
   dword_t     out_pc;
   inst_t      out_inst;
   logic       out_misalign;
   logic [2:0] count;

   int checks = 0;
   int errors = 0;
   iq_entry_t sb[$];

   always #5 clk = ~clk;

   inst_queue #(.DEPTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_pc        (in_pc),
      .in_inst      (in_inst),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_inst     (out_inst),
      .out_misalign (out_misalign),
      .count        (count)
   );

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic tick();
      logic      exp_ready;
      logic      exp_valid;
      iq_entry_t e;
      #1;
      exp_ready = (sb.size() != 4);
      exp_valid = (sb.size() != 0) && !flush;
      chk("count", 96'(count), 96'(sb.size()));
      chk("in_ready", 96'(in_ready), 96'(exp_ready));
      chk("out_valid", 96'(out_valid), 96'(exp_valid));
      if (flush) begin
         sb.delete();
      end else begin
         if (exp_valid) begin
            e = sb[0];
            chk("out_pc", 96'(out_pc), 96'(e.pc));
            chk("out_inst", 96'(out_inst), 96'(e.inst));
            chk("out_misalign", 96'(out_misalign), 96'(e.pc[1:0] != 2'b00));
            if (out_ready) void'(sb.pop_front());
         end
         if (in_valid && exp_ready) begin
            e.pc   = in_pc;
            e.inst = in_inst;
            sb.push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input dword_t pc, input logic ordy, input logic fl);
      in_valid  = v;
      in_pc     = pc;
      in_inst   = pc[31:0] ^ 32'h5a5a_0013;
      out_ready = ordy;
      flush     = fl;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = 64'h0; in_inst = 32'h0;
      @(negedge clk);
      #1;
      chk("rst_count", 96'(count), 96'(0));
      chk("rst_in_ready", 96'(in_ready), 96'(1));
      chk("rst_out_valid", 96'(out_valid), 96'(0));
      chk("rst_out_pc", 96'(out_pc), 96'(0));
      chk("rst_out_inst", 96'(out_inst), 96'(INST_NOP));
      chk("rst_misalign", 96'(out_misalign), 96'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Fill then drain in order
      for (int i = 0; i < 4; i++) drive(1'b1, 64'h1000 + 64'(4 * i), 1'b0, 1'b0);
      drive(1'b1, 64'h1010, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b0, 64'h0, 1'b1, 1'b0);

      // Full with simultaneous pop: refused, then accepted next cycle
      for (int i = 0; i < 4; i++) drive(1'b1, 64'h1100 + 64'(4 * i), 1'b0, 1'b0);
      drive(1'b1, 64'h1200, 1'b1, 1'b0);
      drive(1'b1, 64'h1200, 1'b0, 1'b0);
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b0, 64'h0, 1'b1, 1'b0);

      // Streaming through pointer wrap
      drive(1'b1, 64'h4000, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) drive(1'b1, 64'h4000 + 64'(4 * i), 1'b1, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);

      // Flush with same-cycle push; 0x2000 must never emerge
      drive(1'b1, 64'h5000, 1'b0, 1'b0);
      drive(1'b1, 64'h5004, 1'b0, 1'b0);
      drive(1'b1, 64'h2000, 1'b1, 1'b1);
      drive(1'b1, 64'h2008, 1'b0, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);

      // Misaligned head
      drive(1'b1, 64'h3002, 1'b0, 1'b0);
      drive(1'b1, 64'h3004, 1'b1, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);

      // Asynchronous reset mid-stream with three entries queued
      for (int i = 0; i < 3; i++) drive(1'b1, 64'h6000 + 64'(4 * i), 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", 96'(count), 96'(0));
      chk("arst_out_valid", 96'(out_valid), 96'(0));
      chk("arst_in_ready", 96'(in_ready), 96'(1));
      chk("arst_out_inst", 96'(out_inst), 96'(INST_NOP));
      chk("arst_out_pc", 96'(out_pc), 96'(0));
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 64'h7000, 1'b0, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      drive(1'b0, 64'h0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between fetch and dispatch. It buffers fetched (pc, inst) pairs in a small FIFO and presents the oldest entry to the dispatch decoders (R/I/S/B/U/J) through a valid/ready handshake. A redirect flush from the execute stage discards every buffered entry. The queue decouples fetch-memory latency from dispatch stalls.

## Interface
Parameters:
- DEPTH, 4: number of entries. Must be a power of two, ≥2.
- PTR_W, $clog2(DEPTH): pointer width. Derived; do not override.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset; **asynchronous, active-low**.
- flush  input  1  redirect/flush from execute; empties the queue.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  queue accepts (not full).
- in_pc  input  `dword_t  PC of the fetched instruction.
- in_inst  input  `inst_t  32-bit instruction word.
- out_valid  output  1  head entry is valid for dispatch.
- out_ready  input  1  dispatch consumes the head.
- out_pc  output  `dword_t  PC of the head entry.
- out_inst  output  `inst_t  instruction of the head entry.
- out_misalign  output  1  head PC has bits [1:0] ≠ 0; dispatch raises an instruction-address-misaligned fault.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH × {pc, inst}, plus head pointer, tail pointer (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits).
- push = in_valid & in_ready & !flush. It writes the entry at the tail and increments the tail.
- pop = out_valid & out_ready. It increments the head. out_valid already excludes flush.
- in_ready = (count != DEPTH). It does not depend on out_ready (no combinational path from dispatch to fetch).
- out_valid = (count != 0) & !flush.
- out_pc, out_inst and out_misalign are read from the head entry. They are don't-care when out_valid=0, but must never be X after reset.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full with simultaneous pop: in_ready=0, so no push that cycle. The freed slot is usable from the next cycle.
- Empty: no bypass. An entry pushed in cycle N is visible at the output in cycle N+1.
- flush has priority over everything:
  - head, tail and count go to 0 at the next edge.
  - A same-cycle push is dropped.
  - out_valid=0 in the flush cycle, so no pop occurs.
- Reset (asserted at any time, including mid-transfer): head=tail=count=0 immediately. Storage contents need not be cleared, but the output mux reads entry 0, which is reset to pc=0, inst=32'h00000013 (NOP).

## Timing
- Reset values:
  - in_ready=1, out_valid=0, count=0.
  - out_pc=0, out_inst=32'h00000013, out_misalign=0.
- Latency: push in cycle N, head available in cycle N+1 when the queue was empty.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- flush in cycle N: out_valid=0 in N; count=0 and in_ready=1 in N+1. A push in N+1 is accepted normally.
- Handshake rules:
  - Fetch must hold in_pc/in_inst stable while in_valid=1 and in_ready=0.
  - The queue holds out_* stable while out_valid=1 and out_ready=0.
- Pointer wrap: DEPTH−1 → 0 with no special case (power-of-two width).

## Structure
- Shared defines header: `inst_t, `dword_t, `INST_NOP (32'h00000013), `IQ_DEPTH (default 4).
- One sub-module is natural: sync_fifo. It is a generic parameterised FIFO (WIDTH, DEPTH, clear input), instantiated with WIDTH=96 for {pc, inst}.
- inst_queue adds the flush gating, out_misalign decode and reset-NOP head value.

## Test plan
- Reset then idle: rst_n low mid-stream with count=3 → in the same cycle count=0, out_valid=0, in_ready=1, out_inst=32'h00000013.
- Fill/drain: push pc=0x1000,0x1004,0x1008,0x100C with out_ready=0 → count=4, in_ready=0; then out_ready=1 → outputs appear in order at 0x1000..0x100C, then out_valid=0.
- Full + simultaneous pop: count=4, in_valid=1, out_ready=1 → push refused, count=3; next cycle push accepted, count=4.
- Streaming wrap: 10 back-to-back pushes and pops with DEPTH=4 → count stays at 1, all 10 PCs emerge in order, pointers wrap twice.
- Flush with push: count=2, flush=1 and in_valid=1 with pc=0x2000 → out_valid=0 that cycle; count=0 next cycle; 0x2000 never emitted.
- Misalign: push pc=0x3002 → out_misalign=1 at the head; push pc=0x3004 → out_misalign=0.
